// File: rtl/constraint_sample_driver.sv
// Pseudo-random candidate generator feeding a combinational constraint checker;
// accepted candidates are streamed out on a valid/ready sample interface.
module constraint_sample_driver #(
  parameter int unsigned VEC_W     = 185,
  parameter logic [31:0] SEED      = 32'h1ACE_B00C,
  parameter int unsigned MAX_TRIES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       n_samples,
  output logic [VEC_W-1:0]  cand_o,
  input  logic              sat_i,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [VEC_W-1:0]  sample_data,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [31:0]       tries
);

  localparam int unsigned L          = (VEC_W + 31) / 32;
  localparam logic [31:0] TAPS       = 32'h8020_0003;
  localparam logic [31:0] REJECT_MAX = 32'(MAX_TRIES - 1);

  typedef enum logic [1:0] {IDLE, GEN, HOLD, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] lfsr [L];
  logic [31:0] rejects;
  logic [15:0] delivered;
  logic [15:0] requested;
  logic        start_ok;
  logic        handshake;

  function automatic logic [31:0] seed_of(input int unsigned i);
    logic [31:0] s;
    s = SEED ^ (32'(i) * 32'h9E37_79B9);
    return (s == '0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  // Last LFSR may be only partially visible when VEC_W is not a multiple of 32.
  for (genvar i = 0; i < L; i++) begin : g_cand
    if ((i + 1) * 32 <= VEC_W) begin : g_full
      assign cand_o[i*32 +: 32] = lfsr[i];
    end else begin : g_part
      assign cand_o[VEC_W-1:i*32] = lfsr[i][VEC_W-1-i*32:0];
    end
  end

  assign start_ok  = ((state == IDLE) || (state == DONE)) && start;
  assign handshake = (state == HOLD) && sample_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = (n_samples == '0) ? DONE : GEN;
      end
      GEN: begin
        if (sat_i)                    state_next = HOLD;
        else if (rejects == REJECT_MAX) state_next = DONE;
      end
      HOLD: begin
        if (sample_ready) state_next = (delivered + 16'd1 == requested) ? DONE : GEN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == GEN) || (state == HOLD);
    done         = (state == DONE);
    sample_valid = (state == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < L; i++) lfsr[i] <= seed_of(i);
      sample_data <= '0;
      tries       <= '0;
      rejects     <= '0;
      delivered   <= '0;
      requested   <= '0;
      fail        <= 1'b0;
    end else begin
      if (start_ok) begin
        requested <= n_samples;
        tries     <= '0;
        rejects   <= '0;
        delivered <= '0;
        fail      <= 1'b0;
      end
      if (state == GEN) begin
        if (tries != '1) tries <= tries + 32'd1;
        if (sat_i) begin
          sample_data <= cand_o;
          rejects     <= '0;
        end else if (rejects == REJECT_MAX) begin
          fail <= 1'b1;
        end else begin
          rejects <= rejects + 32'd1;
          for (int unsigned i = 0; i < L; i++) lfsr[i] <= lfsr_step(lfsr[i]);
        end
      end
      if (handshake) begin
        delivered <= delivered + 16'd1;
        for (int unsigned i = 0; i < L; i++) lfsr[i] <= lfsr_step(lfsr[i]);
      end
    end
  end

endmodule
